// File: rtl/sccb_target_model.sv
// SCCB responder emulating the OV7670 register interface: decodes 3-phase
// writes and 2-phase write + 2-phase read sequences against a 256x8 register file.
module sccb_target_model #(
  parameter logic [7:0] DEVICE_ID  = 8'h42,
  parameter bit         ACK_ENABLE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sioc_in,
  input  logic       siod_in,
  output logic       siod_oe,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic [7:0] dbg_addr,
  output logic [7:0] dbg_data,
  output logic       busy,
  output logic       err_nack
);

  typedef enum logic [3:0] {
    IDLE, ID, ID_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RD_NA, IGNORE
  } state_t;

  state_t      state_q;
  logic        siocMeta_q, siocSync_q, siocPrev_q;
  logic        siodMeta_q, siodSync_q, siodPrev_q;
  logic [3:0]  bitCnt_q;
  logic [7:0]  shift_q, rdShift_q, ptr_q;
  logic        isRead_q, naBit_q;
  logic        siodOe_q, busy_q, errNack_q;
  logic        wrValid_q;
  logic [7:0]  wrAddr_q, wrData_q;
  logic [7:0]  regFile_q [256];

  logic        siocRise, siocFall, startEv, stopEv, memWe;
  logic [7:0]  shift_d, rdByte;

  // Pins idle high, so the synchronisers reset to 1 to avoid a phantom START.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {siocMeta_q, siocSync_q, siocPrev_q} <= 3'b111;
      {siodMeta_q, siodSync_q, siodPrev_q} <= 3'b111;
    end else begin
      siocMeta_q <= sioc_in;
      siocSync_q <= siocMeta_q;
      siocPrev_q <= siocSync_q;
      siodMeta_q <= siod_in;
      siodSync_q <= siodMeta_q;
      siodPrev_q <= siodSync_q;
    end
  end

  assign siocRise = siocSync_q & ~siocPrev_q;
  assign siocFall = ~siocSync_q & siocPrev_q;
  assign startEv  = siocSync_q & siocPrev_q & siodPrev_q & ~siodSync_q;
  assign stopEv   = siocSync_q & siocPrev_q & ~siodPrev_q & siodSync_q;
  assign shift_d  = {shift_q[6:0], siodSync_q};
  assign rdByte   = regFile_q[ptr_q];
  assign memWe    = siocRise && (state_q == WDATA) && (bitCnt_q == 4'd7);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) regFile_q[i] <= 8'h00;
    end else if (memWe) begin
      regFile_q[ptr_q] <= shift_d;
    end
  end

  // STOP and START override every state; otherwise bytes shift in on SIOC
  // rises and SIOD is only ever changed on SIOC falls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bitCnt_q  <= 4'd0;
      shift_q   <= 8'h00;
      rdShift_q <= 8'h00;
      ptr_q     <= 8'h00;
      isRead_q  <= 1'b0;
      naBit_q   <= 1'b0;
      siodOe_q  <= 1'b0;
      busy_q    <= 1'b0;
      errNack_q <= 1'b0;
      wrValid_q <= 1'b0;
      wrAddr_q  <= 8'h00;
      wrData_q  <= 8'h00;
    end else begin
      wrValid_q <= 1'b0;
      if (stopEv) begin
        state_q  <= IDLE;
        siodOe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else if (startEv) begin
        state_q  <= ID;
        bitCnt_q <= 4'd0;
        busy_q   <= 1'b1;
      end else begin
        case (state_q)
          ID, SUB, WDATA: begin
            if (siocRise && bitCnt_q < 4'd8) begin
              shift_q  <= shift_d;
              bitCnt_q <= bitCnt_q + 4'd1;
              if (state_q == WDATA && bitCnt_q == 4'd7) begin
                wrValid_q <= 1'b1;
                wrAddr_q  <= ptr_q;
                wrData_q  <= shift_d;
                ptr_q     <= ptr_q + 8'd1;
              end
            end else if (siocFall && bitCnt_q == 4'd8) begin
              bitCnt_q <= 4'd0;
              if (state_q == ID) begin
                if (shift_q == DEVICE_ID || shift_q == (DEVICE_ID | 8'h01)) begin
                  state_q  <= ID_ACK;
                  isRead_q <= (shift_q == (DEVICE_ID | 8'h01));
                  siodOe_q <= ACK_ENABLE;
                end else begin
                  state_q   <= IGNORE;
                  errNack_q <= 1'b1;
                end
              end else if (state_q == SUB) begin
                ptr_q    <= shift_q;
                state_q  <= SUB_ACK;
                siodOe_q <= ACK_ENABLE;
              end else begin
                state_q  <= WDATA_ACK;
                siodOe_q <= ACK_ENABLE;
              end
            end
          end
          ID_ACK: begin
            if (siocFall) begin
              if (isRead_q) begin
                rdShift_q <= {rdByte[6:0], 1'b0};
                siodOe_q  <= ~rdByte[7];
                bitCnt_q  <= 4'd1;
                state_q   <= RDATA;
              end else begin
                siodOe_q <= 1'b0;
                bitCnt_q <= 4'd0;
                state_q  <= SUB;
              end
            end
          end
          SUB_ACK, WDATA_ACK: begin
            if (siocFall) begin
              siodOe_q <= 1'b0;
              bitCnt_q <= 4'd0;
              state_q  <= WDATA;
            end
          end
          RDATA: begin
            if (siocFall) begin
              if (bitCnt_q < 4'd8) begin
                siodOe_q  <= ~rdShift_q[7];
                rdShift_q <= {rdShift_q[6:0], 1'b0};
                bitCnt_q  <= bitCnt_q + 4'd1;
              end else begin
                siodOe_q <= 1'b0;
                bitCnt_q <= 4'd0;
                ptr_q    <= ptr_q + 8'd1;
                state_q  <= RD_NA;
              end
            end
          end
          RD_NA: begin
            if (siocRise) begin
              naBit_q <= siodSync_q;
            end else if (siocFall) begin
              if (naBit_q) begin
                state_q <= IGNORE;
              end else begin
                rdShift_q <= {rdByte[6:0], 1'b0};
                siodOe_q  <= ~rdByte[7];
                bitCnt_q  <= 4'd1;
                state_q   <= RDATA;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign siod_oe  = siodOe_q;
  assign wr_valid = wrValid_q;
  assign wr_addr  = wrAddr_q;
  assign wr_data  = wrData_q;
  assign busy     = busy_q;
  assign err_nack = errNack_q;
  assign dbg_data = regFile_q[dbg_addr];

endmodule

// File: tb/tb_sccb_target_model.sv
// Bench for sccb_target_model: an SCCB master drives the open-drain bus while a
// register model and write/read scoreboards supply every expected value.
`timescale 1ns/1ps
module tb_sccb_target_model;

  localparam logic [7:0] DEV_ID = 8'h42;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wrExp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       sioc;
  logic       siodM;
  wire        siodBus;
  logic       siodOe;
  logic       wrValid;
  logic [7:0] wrAddr, wrData;
  logic [7:0] dbgAddr, dbgData;
  logic       busy, errNack;

  int         checks = 0;
  int         errors = 0;
  int         q = 4;
  int         oeCount = 0;
  int         wrPulses = 0;
  int         expPulses = 0;
  logic [7:0] model [256];
  logic [7:0] modelPtr;
  wrExp_t     expWrQ [$];
  logic [7:0] expRdQ [$];

  always #20 clk = ~clk;

  assign siodBus = siodM & ~siodOe;

  sccb_target_model #(.DEVICE_ID(DEV_ID), .ACK_ENABLE(1'b1)) dut (
    .clk(clk), .rst(rst), .sioc_in(sioc), .siod_in(siodBus), .siod_oe(siodOe),
    .wr_valid(wrValid), .wr_addr(wrAddr), .wr_data(wrData),
    .dbg_addr(dbgAddr), .dbg_data(dbgData), .busy(busy), .err_nack(errNack)
  );

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Every wr_valid cycle must match the next queued write.
  always @(negedge clk) begin
    if (siodOe) oeCount <= oeCount + 1;
    if (!rst && wrValid) begin
      wrPulses <= wrPulses + 1;
      if (expWrQ.size() == 0) begin
        checkOutput("wr_unexpected", 32'(expWrQ.size()), 32'd1);
      end else begin
        wrExp_t e;
        e = expWrQ.pop_front();
        checkOutput("wr_addr", {24'd0, wrAddr}, {24'd0, e.addr});
        checkOutput("wr_data", {24'd0, wrData}, {24'd0, e.data});
      end
    end
  end

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sendBit(input logic b, output logic sampled, output logic oeAtSample);
    waitClk(q); siodM = b;
    waitClk(q); sioc = 1'b1;
    waitClk(q); sampled = siodBus; oeAtSample = siodOe;
    waitClk(q); sioc = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b, output logic ack);
    logic s, o;
    for (int i = 7; i >= 0; i--) sendBit(b[i], s, o);
    sendBit(1'b1, ack, o);
  endtask

  task automatic readByte(input logic na, output logic [7:0] d, output logic naOe);
    logic s, o;
    for (int i = 7; i >= 0; i--) begin
      sendBit(1'b1, s, o);
      d[i] = s;
    end
    sendBit(na, s, naOe);
  endtask

  task automatic busStart();
    siodM = 1'b1; waitClk(q);
    sioc  = 1'b1; waitClk(q);
    siodM = 1'b0; waitClk(q);
    sioc  = 1'b0;
  endtask

  task automatic busStop();
    waitClk(q); siodM = 1'b0;
    waitClk(q); sioc  = 1'b1;
    waitClk(q); siodM = 1'b1;
    waitClk(q + 4);
  endtask

  task automatic checkReg(input logic [7:0] a);
    dbgAddr = a;
    #1;
    checkOutput($sformatf("reg_%02h", a), {24'd0, dbgData}, {24'd0, model[a]});
  endtask

  // Full write transaction of n bytes (ID first); expected writes are queued before each data byte is sent.
  task automatic applyStimulus(input logic [7:0] id, input logic [7:0] b1,
                               input logic [7:0] b2, input logic [7:0] b3, input int n);
    logic [7:0] bs [4];
    logic       ack, accept;
    wrExp_t     e;
    bs[0] = id; bs[1] = b1; bs[2] = b2; bs[3] = b3;
    accept = (id == DEV_ID);
    busStart();
    for (int k = 0; k < n; k++) begin
      if (accept && k >= 2) begin
        e.addr = modelPtr;
        e.data = bs[k];
        expWrQ.push_back(e);
        model[modelPtr] = bs[k];
        modelPtr = modelPtr + 8'd1;
        expPulses++;
      end
      sendByte(bs[k], ack);
      checkOutput($sformatf("ack_b%0d_%02h", k, bs[k]), {31'd0, ack}, accept ? 32'd0 : 32'd1);
      if (k == 0) checkOutput("busy_xfer", {31'd0, busy}, 32'd1);
      if (accept && k == 1) modelPtr = bs[k];
    end
    busStop();
    checkOutput("busy_after_stop", {31'd0, busy}, 32'd0);
  endtask

  task automatic readTransaction(input int n);
    logic       ack, naOe;
    logic [7:0] d, exp;
    busStart();
    sendByte(DEV_ID | 8'h01, ack);
    checkOutput("ack_rd_id", {31'd0, ack}, 32'd0);
    for (int i = 0; i < n; i++) begin
      expRdQ.push_back(model[modelPtr]);
      readByte(i == n - 1, d, naOe);
      exp = expRdQ.pop_front();
      checkOutput($sformatf("rd_data%0d", i), {24'd0, d}, {24'd0, exp});
      checkOutput($sformatf("rd_na_released%0d", i), {31'd0, naOe}, 32'd0);
      modelPtr = modelPtr + 8'd1;
    end
    busStop();
    checkOutput("busy_after_read", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic ack, s, o;
    logic [7:0] id;
    int   oeBefore, waited;

    rst = 1'b1; sioc = 1'b1; siodM = 1'b1; dbgAddr = 8'h00;
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
    modelPtr = 8'h00;
    waitClk(3);
    checkOutput("rst_siod_oe", {31'd0, siodOe}, 32'd0);
    checkOutput("rst_wr_valid", {31'd0, wrValid}, 32'd0);
    checkOutput("rst_wr_addr", {24'd0, wrAddr}, 32'd0);
    checkOutput("rst_wr_data", {24'd0, wrData}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_err_nack", {31'd0, errNack}, 32'd0);
    rst = 1'b0;
    waitClk(4);

    $display("[TB] 3-phase write at ~100 kHz SIOC");
    q = 62;
    applyStimulus(8'h42, 8'h12, 8'h80, 8'h00, 3);
    checkReg(8'h12);
    q = 4;

    $display("[TB] write then 2-phase pointer set then read");
    applyStimulus(8'h42, 8'h0A, 8'h55, 8'h66, 4);
    applyStimulus(8'h42, 8'h0A, 8'h00, 8'h00, 2);
    readTransaction(2);
    checkOutput("err_nack_clean", {31'd0, errNack}, 32'd0);

    $display("[TB] wrong device ID");
    oeBefore = oeCount;
    applyStimulus(8'h60, 8'h12, 8'h34, 8'h00, 3);
    checkOutput("oe_quiet_bad_id", 32'(oeCount - oeBefore), 32'd0);
    checkOutput("err_nack_set", {31'd0, errNack}, 32'd1);
    checkReg(8'h12);
    checkReg(8'h34);

    $display("[TB] multi-byte write with pointer wrap");
    applyStimulus(8'h42, 8'hFF, 8'h11, 8'h22, 4);
    checkReg(8'hFF);
    checkReg(8'h00);

    $display("[TB] STOP mid data byte, then full write");
    busStart();
    sendByte(8'h42, ack);
    checkOutput("ack_abort_id", {31'd0, ack}, 32'd0);
    sendByte(8'h01, ack);
    checkOutput("ack_abort_sub", {31'd0, ack}, 32'd0);
    modelPtr = 8'h01;
    sendBit(1'b1, s, o); sendBit(1'b0, s, o); sendBit(1'b1, s, o); sendBit(1'b0, s, o);
    busStop();
    checkReg(8'h01);
    applyStimulus(8'h42, 8'h01, 8'hAA, 8'h00, 3);
    checkReg(8'h01);
    checkOutput("wr_queue_drained", 32'(expWrQ.size()), 32'd0);
    checkOutput("wr_pulse_count", 32'(wrPulses), 32'(expPulses));

    $display("[TB] reset during ID acknowledge");
    busStart();
    id = DEV_ID;
    for (int i = 7; i >= 0; i--) sendBit(id[i], s, o);
    waited = 0;
    while (!siodOe && waited < 20) begin
      waitClk(1);
      waited++;
    end
    checkOutput("oe_before_reset", {31'd0, siodOe}, 32'd1);
    #3 rst = 1'b1;
    #1;
    checkOutput("oe_async_reset", {31'd0, siodOe}, 32'd0);
    checkOutput("busy_async_reset", {31'd0, busy}, 32'd0);
    checkOutput("err_nack_reset", {31'd0, errNack}, 32'd0);
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
    modelPtr = 8'h00;
    waitClk(2);
    rst = 1'b0;
    siodM = 1'b1;
    waitClk(2);
    sioc = 1'b1;
    waitClk(6);
    checkReg(8'h12);
    checkReg(8'h0A);
    checkReg(8'hFF);
    checkReg(8'h01);
    checkOutput("busy_idle_end", {31'd0, busy}, 32'd0);

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
